// File: rtl/nn_pkg.sv
// nn_pkg: shared FSM state type, default widths and the ReLU helper for the neuron datapath
package nn_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, ACCUM, OUT} state_t;
  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF = 20;
  function automatic logic signed [63:0] relu(input logic en, input logic signed [63:0] v);
    return (en && v < 0) ? 64'sd0 : v;
  endfunction
endpackage

// File: rtl/mac_unit.sv
// mac_unit: combinational signed multiply, sign-extend and accumulate
module mac_unit #(
  parameter int DATA_W = 8,
  parameter int ACC_W = 20
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] w,
  output logic signed [ACC_W-1:0]  acc_next
);
  logic signed [2*DATA_W-1:0] prod;
  assign prod = x * w;
  assign acc_next = acc + ACC_W'(prod);
endmodule

// File: rtl/neuron_mac_sequencer.sv
// neuron_mac_sequencer: sequences 16 MAC steps plus bias over an external index counter and hands the result downstream
module neuron_mac_sequencer
  import nn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     relu_en,
  input  logic signed [DATA_W-1:0] bias,
  input  logic signed [DATA_W-1:0] x_data,
  input  logic signed [DATA_W-1:0] w_data,
  input  logic [3:0]               cnt_value,
  input  logic                     cnt_last,
  output logic                     cnt_clear,
  output logic                     cnt_increment,
  output logic                     busy,
  output logic signed [ACC_W-1:0]  y_data,
  output logic                     y_valid,
  input  logic                     y_ready
);
  state_t state, next;
  logic signed [ACC_W-1:0] acc, acc_next;
  logic relu_q;
  logic unused_cnt;
  assign unused_cnt = ^cnt_value;
  mac_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
    .acc(acc),
    .x(x_data),
    .w(w_data),
    .acc_next(acc_next)
  );
  // state register, accumulator, relu mode and result capture
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      acc <= '0;
      y_data <= '0;
      relu_q <= 1'b0;
    end else begin
      state <= next;
      if (state == IDLE && start) relu_q <= relu_en;
      if (state == CLEAR) acc <= ACC_W'(bias);
      if (state == ACCUM) acc <= acc_next;
      if (state == ACCUM && cnt_last) y_data <= ACC_W'(relu(relu_q, 64'(acc_next)));
    end
  end
  // next-state decode; the counter flag ends ACCUM, downstream ready ends OUT
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start ? CLEAR : IDLE;
      CLEAR:   next = ACCUM;
      ACCUM:   next = cnt_last ? OUT : ACCUM;
      OUT:     next = y_ready ? IDLE : OUT;
      default: next = IDLE;
    endcase
  end
  assign cnt_clear = (state == CLEAR) | ~reset_n;
  assign cnt_increment = (state == ACCUM) & ~cnt_last;
  assign busy = state != IDLE;
  assign y_valid = state == OUT;
endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// tb_neuron_mac_sequencer: directed checks of neuron_mac_sequencer against hand-computed results
module tb_neuron_mac_sequencer;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic relu_en = 1'b0;
  logic signed [7:0] bias = '0;
  logic signed [7:0] x_data, w_data;
  logic [3:0] cnt_value;
  logic cnt_last;
  logic cnt_clear, cnt_increment, busy, y_valid;
  logic [19:0] y_data;
  logic y_ready = 1'b1;
  logic signed [7:0] xs [16];
  logic signed [7:0] ws [16];
  int tests = 0;
  int failed = 0;
  int inc_total = 0;
  int clr_total = 0;
  int lat, inc0, clr0, wait_n;
  logic [19:0] held;

  always #5 clock = ~clock;

  neuron_mac_sequencer dut (
    .clock(clock),
    .reset_n(reset_n),
    .start(start),
    .relu_en(relu_en),
    .bias(bias),
    .x_data(x_data),
    .w_data(w_data),
    .cnt_value(cnt_value),
    .cnt_last(cnt_last),
    .cnt_clear(cnt_clear),
    .cnt_increment(cnt_increment),
    .busy(busy),
    .y_data(y_data),
    .y_valid(y_valid),
    .y_ready(y_ready)
  );

  // external 4-bit index counter model with no reset of its own
  always @(posedge clock) begin
    if (cnt_clear) cnt_value <= 4'd0;
    else if (cnt_increment) cnt_value <= cnt_value + 4'd1;
  end
  assign cnt_last = cnt_value == 4'd15;
  assign x_data = xs[cnt_value];
  assign w_data = ws[cnt_value];

  // pulse counters for the counter-control outputs
  always @(posedge clock) begin
    if (cnt_increment) inc_total <= inc_total + 1;
    if (cnt_clear) clr_total <= clr_total + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic signed [7:0] xv, input logic signed [7:0] wv);
    for (int i = 0; i < 16; i++) begin
      xs[i] = xv;
      ws[i] = wv;
    end
  endtask

  task automatic pulse_start(input logic r, input logic signed [7:0] b);
    @(negedge clock);
    bias = b;
    relu_en = r;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    relu_en = 1'b0;
  endtask

  task automatic wait_valid(output int l);
    l = 1;
    while (!y_valid && l < 60) begin
      @(negedge clock);
      l++;
    end
  endtask

  task automatic run(input logic r, input logic signed [7:0] b, output int l);
    pulse_start(r, b);
    wait_valid(l);
  endtask

  initial begin
    fill(8'sd0, 8'sd0);
    repeat (2) @(negedge clock);
    chk("rst_clear", 32'(cnt_clear), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(y_valid), 32'd0);
    chk("rst_ydata", 32'(y_data), 32'd0);
    chk("rst_inc", 32'(cnt_increment), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_clear", 32'(cnt_clear), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    fill(8'sd1, 8'sd1);
    inc0 = inc_total;
    clr0 = clr_total;
    run(1'b0, 8'sd0, lat);
    chk("ones_latency", 32'(lat), 32'd18);
    chk("ones_y", 32'(y_data), 32'h00010);
    chk("ones_inc_pulses", 32'(inc_total - inc0), 32'd15);
    chk("ones_clr_pulses", 32'(clr_total - clr0), 32'd1);
    @(negedge clock);
    chk("ones_out_1cycle", 32'(y_valid), 32'd0);
    chk("ones_idle", 32'(busy), 32'd0);

    fill(-8'sd3, 8'sd5);
    run(1'b0, 8'sd10, lat);
    chk("neg_latency", 32'(lat), 32'd18);
    chk("neg_y", 32'(y_data), 32'h000FFF1A);
    @(negedge clock);
    run(1'b1, 8'sd10, lat);
    chk("neg_relu_y", 32'(y_data), 32'd0);
    @(negedge clock);

    fill(-8'sd128, -8'sd128);
    run(1'b0, 8'sd127, lat);
    chk("max_y", 32'(y_data), 32'h0004007F);
    @(negedge clock);

    for (int i = 0; i < 16; i++) begin
      xs[i] = 8'(i);
      ws[i] = 8'sd1;
    end
    run(1'b1, 8'sd5, lat);
    chk("ramp_y", 32'(y_data), 32'd125);
    @(negedge clock);

    fill(8'sd1, 8'sd1);
    y_ready = 1'b0;
    run(1'b0, 8'sd0, lat);
    chk("bp_latency", 32'(lat), 32'd18);
    held = y_data;
    fill(8'sd7, 8'sd7);
    for (int i = 0; i < 5; i++) begin
      start = (i % 2) == 0;
      @(negedge clock);
      chk("bp_valid", 32'(y_valid), 32'd1);
      chk("bp_hold", 32'(y_data), 32'(held));
    end
    start = 1'b1;
    y_ready = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("bp_exit_idle", 32'(busy), 32'd0);
    chk("bp_exit_valid", 32'(y_valid), 32'd0);
    @(negedge clock);
    chk("bp_start_ignored", 32'(busy), 32'd0);
    chk("bp_y_kept", 32'(y_data), 32'h00010);
    run(1'b0, 8'sd1, lat);
    chk("bp_fresh_y", 32'(y_data), 32'd785);
    @(negedge clock);

    fill(8'sd9, 8'sd9);
    pulse_start(1'b0, 8'sd0);
    wait_n = 0;
    while (!(busy && cnt_value == 4'd7 && !cnt_clear) && wait_n < 40) begin
      @(negedge clock);
      wait_n++;
    end
    chk("mid_reached_idx7", 32'(cnt_value), 32'd7);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_clear", 32'(cnt_clear), 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_valid", 32'(y_valid), 32'd0);
    chk("mid_ydata", 32'(y_data), 32'd0);
    fill(8'sd2, 8'sd3);
    run(1'b0, -8'sd1, lat);
    chk("mid_after_latency", 32'(lat), 32'd18);
    chk("mid_after_y", 32'(y_data), 32'd95);
    @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/neuron_mac_sequencer.md
# neuron_mac_sequencer

Control-and-datapath stage for one 16-input neuron. It drives the shared 4-bit index counter through its clear and increment inputs, and it consumes the counter's value and last-value flag. It accumulates 16 signed activation×weight products plus a bias, optionally applies ReLU, and presents the result to the downstream layer over a valid/ready handshake.

## Interface
- DATA_W, default 8: signed width of activation, weight and bias.
- ACC_W, default 20: signed accumulator and result width. Must satisfy ACC_W ≥ 2·DATA_W+4.
- clock  in  1  single clock; all state changes on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  request one neuron evaluation; sampled only in IDLE.
- relu_en  in  1  apply ReLU to this evaluation; captured with start.
- bias  in  DATA_W  signed bias; captured in CLEAR.
- x_data  in  DATA_W  signed activation at index cnt_value; valid every ACCUM cycle.
- w_data  in  DATA_W  signed weight at index cnt_value; valid every ACCUM cycle.
- cnt_value  in  4  index from the counter.
- cnt_last  in  1  counter at 15.
- cnt_clear  out  1  clear request to the counter.
- cnt_increment  out  1  increment request to the counter.
- busy  out  1  high in any state other than IDLE.
- y_data  out  ACC_W  signed result, registered.
- y_valid  out  1  result available.
- y_ready  in  1  downstream accepts the result.

## Operation
- FSM states are IDLE, CLEAR, ACCUM and OUT.
- IDLE
  - start=1 → CLEAR. relu_en is latched on this edge.
  - Otherwise the FSM stays in IDLE.
- CLEAR
  - Lasts one cycle; cnt_clear=1.
  - acc ← sign-extended bias.
  - Next state is ACCUM.
- ACCUM
  - Each cycle: acc ← acc + sign-extended (x_data·w_data).
  - cnt_increment = ~cnt_last, so the counter never wraps.
  - If cnt_last=1, the index-15 product is still included, and the FSM moves to OUT.
  - On that same edge: y_data ← (relu_q && acc_next<0) ? 0 : acc_next.
- OUT
  - y_valid=1; y_data is held stable.
  - y_valid && y_ready → IDLE.
  - y_ready low → remain in OUT indefinitely.
- Combinational outputs:
  - cnt_clear = (state==CLEAR) | ~reset_n. The counter has no reset of its own.
  - cnt_increment = (state==ACCUM) & ~cnt_last.
- Arithmetic: the product is full 2·DATA_W signed. All sums are in ACC_W two's complement. At the defaults, overflow is impossible and no saturation logic exists.
- start is ignored while busy=1. A start that coincides with the OUT→IDLE edge is also ignored; start is only seen on a later IDLE cycle.
- Reset, including mid-evaluation, has the following effect at the next edge:
  - state=IDLE.
  - acc=0, y_data=0, y_valid=0.
  - relu_q=0, busy=0.
  - cnt_clear=1 while reset_n=0.
- Reset values: y_data=0, y_valid=0, busy=0, cnt_increment=0, cnt_clear=1 (during reset) / 0 (after).

## Timing
- Edge 0: start sampled high.
- Cycle 1: CLEAR.
- Cycles 2–17: ACCUM, indices 0..15, one product per cycle.
- Cycle 18: y_valid=1 at the earliest.
- Latency from start to y_valid is 18 cycles.
- Issue interval with y_ready tied high is 19 cycles: OUT lasts one cycle, then IDLE lasts at least one cycle.
- x_data and w_data must be valid in the same cycle that cnt_value shows their index. They are combinational reads from upstream buffers, with no read latency.
- The counter is cleared on the CLEAR→ACCUM edge, so cnt_value=0 in the first ACCUM cycle.

## Structure
- Shared package nn_pkg holds:
  - the state enum (IDLE, CLEAR, ACCUM, OUT);
  - default DATA_W and ACC_W;
  - the relu function.
- One sub-module, mac_unit: a combinational signed multiply, sign-extend and add producing acc_next. The FSM and registers stay in the top module.

## Test plan
- All x=1, w=1, bias=0, relu_en=0 → y_data=16 (0x00010) at cycle 18. Exactly 15 cnt_increment pulses and 1 cnt_clear pulse.
- All x=−3, w=5, bias=10, relu_en=0 → y_data=−230 (0xFFF1A). Repeating with relu_en=1 → y_data=0.
- All x=−128, w=−128, bias=127 → y_data=262271 (0x4007F); no overflow.
- Backpressure:
  - Stimulus: y_ready held low for 5 cycles after y_valid rises, with start pulsed during that window.
  - Required: y_valid and y_data are stable and the start pulses are ignored. After y_ready rises, the FSM returns to IDLE and a new start begins a fresh evaluation.
- Reset mid-evaluation:
  - Stimulus: reset_n low for 1 cycle while cnt_value=7 in ACCUM.
  - Required: next cycle shows IDLE, busy=0, y_valid=0, with cnt_clear=1 during reset. A subsequent run with all x=2, w=3, bias=−1 → y_data=95.
